// File: rtl/p_update_sequencer_pkg.sv
// Shared CG solver definitions: memP geometry, default datapath latency and
// the p-update sequencer state encoding.
package p_update_sequencer_pkg;

  localparam int ELEMENT_WIDTH    = 32;
  localparam int NO_OF_UNITS      = 8;
  localparam int ADDRESS_WIDTH    = 20;
  localparam int MAX_ROWS         = 1001;
  localparam int DATAPATH_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Requested rows beyond the memP depth are silently truncated to the depth.
  function automatic logic [31:0] clamp_rows(input logic [31:0] requested,
                                             input logic [31:0] limit);
    return (requested > limit) ? limit : requested;
  endfunction

endpackage

// File: rtl/p_update_sequencer_if.sv
// Handshake and memP bus between the p-update sequencer, the p = r + beta*p
// datapath and memP.
interface p_update_sequencer_if
  import p_update_sequencer_pkg::*;
#(
  parameter int element_width = ELEMENT_WIDTH,
  parameter int no_of_units   = NO_OF_UNITS,
  parameter int address_width = ADDRESS_WIDTH
);

  logic                                 start;
  logic [address_width-1:0]             row_count;
  logic [address_width-1:0]             read_address;
  logic                                 dp_issue;
  logic [no_of_units*element_width-1:0] dp_result;
  logic [address_width-1:0]             write_address;
  logic [no_of_units*element_width-1:0] write_data;
  logic                                 write_enable;
  logic                                 busy;
  logic                                 finish;

  // Controller / datapath side: requests passes and supplies result rows.
  modport master (
    output start,
    output row_count,
    output dp_result,
    input  read_address,
    input  dp_issue,
    input  write_address,
    input  write_data,
    input  write_enable,
    input  busy,
    input  finish
  );

  // Sequencer side.
  modport slave (
    input  start,
    input  row_count,
    input  dp_result,
    output read_address,
    output dp_issue,
    output write_address,
    output write_data,
    output write_enable,
    output busy,
    output finish
  );

endinterface

// File: rtl/p_update_sequencer_valid_addr_delay_line.sv
// Carries the issued-row valid bit and row address alongside the datapath so
// the result row can be matched to its memP write address at the tail.
module valid_addr_delay_line #(
  parameter int depth      = 4,
  parameter int addr_width = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_i,
  input  logic [addr_width-1:0] in_addr_i,
  output logic                  out_valid_o,
  output logic [addr_width-1:0] out_addr_o
);

  logic [depth-1:0]      valid_q;
  logic [addr_width-1:0] addr_q [depth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q[0] <= 1'b0;
      addr_q[0]  <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      addr_q[0]  <= in_addr_i;
    end
  end

  // Clearing the valids on reset is what discards rows still in flight.
  for (genvar gi = 1; gi < depth; gi++) begin : g_stage
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q[gi] <= 1'b0;
        addr_q[gi]  <= '0;
      end else begin
        valid_q[gi] <= valid_q[gi-1];
        addr_q[gi]  <= addr_q[gi-1];
      end
    end
  end

  assign out_valid_o = valid_q[depth-1];
  assign out_addr_o  = addr_q[depth-1];

endmodule

// File: rtl/p_update_sequencer.sv
// Streams memP rows 0..N-1 through the p = r + beta*p datapath, one per cycle,
// and writes each result row back to the same address after the fixed latency.
module p_update_sequencer
  import p_update_sequencer_pkg::*;
#(
  parameter int element_width    = ELEMENT_WIDTH,
  parameter int no_of_units      = NO_OF_UNITS,
  parameter int address_width    = ADDRESS_WIDTH,
  parameter int datapath_latency = DATAPATH_LATENCY,
  parameter int max_rows         = MAX_ROWS
) (
  input  logic                 clk,
  input  logic                 reset,
  p_update_sequencer_if.slave  bus
);

  localparam int row_width = no_of_units * element_width;

  seq_state_e               state_q, state_d;
  logic [address_width-1:0] rows_q, rows_d;
  logic [address_width-1:0] rd_addr_q, rd_addr_d;
  logic [address_width-1:0] wr_addr_q;
  logic [row_width-1:0]     wr_data_q;
  logic                     wr_en_q;

  logic [address_width-1:0] rows_requested;
  logic [address_width-1:0] last_row;
  logic                     issue_active;
  logic                     tail_valid;
  logic [address_width-1:0] tail_addr;

  assign rows_requested = address_width'(clamp_rows(32'(bus.row_count), 32'(max_rows)));
  assign last_row       = rows_q - address_width'(1);
  assign issue_active   = (state_q == ISSUE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rows_d    = rows_requested;
          rd_addr_d = '0;
          state_d   = (rows_requested == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        // The counter parks on the last row so read_address holds during DRAIN.
        if (rd_addr_q == last_row) begin
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + address_width'(1);
        end
      end
      DRAIN: begin
        if (wr_en_q && (wr_addr_q == last_row)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  valid_addr_delay_line #(
    .depth      (datapath_latency),
    .addr_width (address_width)
  ) u_valid_addr_delay_line (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (issue_active),
    .in_addr_i   (rd_addr_q),
    .out_valid_o (tail_valid),
    .out_addr_o  (tail_addr)
  );

  // dp_result is only meaningful in the cycle the matching row reaches the tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= tail_valid;
      if (tail_valid) begin
        wr_addr_q <= tail_addr;
        wr_data_q <= bus.dp_result;
      end
    end
  end

  assign bus.read_address  = rd_addr_q;
  assign bus.dp_issue      = issue_active;
  assign bus.write_address = wr_addr_q;
  assign bus.write_data    = wr_data_q;
  assign bus.write_enable  = wr_en_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.finish        = (state_q == DONE);

endmodule

// File: tb/tb_p_update_sequencer.sv
// Self-checking bench for p_update_sequencer: a datapath model feeds replicated
// row addresses back, and a scoreboard matches every write against its issue.
module tb_p_update_sequencer;
  import p_update_sequencer_pkg::*;

  localparam int LAT = 4;
  localparam int EW  = 32;
  localparam int NU  = 8;
  localparam int AW  = 20;
  localparam int RW  = EW * NU;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  p_update_sequencer_if #(.element_width(EW), .no_of_units(NU), .address_width(AW)) bus ();

  p_update_sequencer #(
    .element_width    (EW),
    .no_of_units      (NU),
    .address_width    (AW),
    .datapath_latency (LAT),
    .max_rows         (1001)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int wr_count    = 0;
  int fin_count   = 0;
  int last_wr_addr = -1;
  bit mon_en      = 1'b0;

  typedef struct {
    int addr;
    int due;
  } exp_t;
  exp_t sb[$];

  function automatic logic [RW-1:0] rep_row(input logic [AW-1:0] a);
    logic [RW-1:0] r;
    for (int u = 0; u < NU; u++) r[u*EW +: EW] = EW'(a);
    return r;
  endfunction

  // Datapath model: result row for the address issued LAT cycles earlier, noise otherwise.
  logic          pv [LAT];
  logic [AW-1:0] pa [LAT];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    pv[0] <= bus.dp_issue;
    pa[0] <= bus.read_address;
    if (pv[LAT-2] === 1'b1)
      bus.dp_result <= rep_row(pa[LAT-2]);
    else
      bus.dp_result <= {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
  end

  // Scoreboard: push on issue, pop and compare on write.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus.dp_issue) sb.push_back('{addr: int'(bus.read_address), due: cyc + LAT + 1});
      if (bus.write_enable) begin
        wr_count++;
        last_wr_addr = int'(bus.write_address);
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected_write: got write addr=%0d at cycle %0d, expected no write",
                   bus.write_address, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (int'(bus.write_address) !== e.addr) begin
            miscompares++;
            $display("FAIL sb_write_addr: got %0d, expected %0d", bus.write_address, e.addr);
          end
          vectors++;
          if (bus.write_data !== rep_row(AW'(e.addr))) begin
            miscompares++;
            $display("FAIL sb_write_data: got %h, expected row of addr %0d", bus.write_data, e.addr);
          end
          vectors++;
          if (cyc !== e.due) begin
            miscompares++;
            $display("FAIL sb_write_time: got cycle %0d, expected cycle %0d", cyc, e.due);
          end
        end
        $display("write addr=%0d cycle=%0d", bus.write_address, cyc);
      end
      if (bus.finish) fin_count++;
    end
  end

  task automatic launch(input int rows);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.row_count = AW'(rows);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.finish === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.row_count = '0;
    repeat (2) @(negedge clk);
    vectors += 7;
    if (bus.read_address !== '0)  begin miscompares++; $display("FAIL rst_read_address: got %0d, expected 0", bus.read_address); end
    if (bus.write_address !== '0) begin miscompares++; $display("FAIL rst_write_address: got %0d, expected 0", bus.write_address); end
    if (bus.write_data !== '0)    begin miscompares++; $display("FAIL rst_write_data: got %h, expected 0", bus.write_data); end
    if (bus.write_enable !== 1'b0) begin miscompares++; $display("FAIL rst_write_enable: got %b, expected 0", bus.write_enable); end
    if (bus.dp_issue !== 1'b0)    begin miscompares++; $display("FAIL rst_dp_issue: got %b, expected 0", bus.dp_issue); end
    if (bus.busy !== 1'b0)        begin miscompares++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
    if (bus.finish !== 1'b0)      begin miscompares++; $display("FAIL rst_finish: got %b, expected 0", bus.finish); end
    $display("reset check done");
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Cycle-exact timeline of a 5-row pass; cycle 0 is the start cycle.
  task automatic test_five_rows;
    logic          e_issue, e_we, e_fin, e_busy;
    logic [AW-1:0] e_raddr;
    wr_count = 0; fin_count = 0;
    launch(5);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      e_issue = (k >= 1 && k <= 5);
      e_raddr = (k <= 5) ? AW'(k - 1) : AW'(4);
      e_we    = (k >= 6 && k <= 10);
      e_fin   = (k == 11);
      e_busy  = (k <= 11);
      vectors += 5;
      if (bus.dp_issue !== e_issue) begin miscompares++; $display("FAIL five_dp_issue c%0d: got %b, expected %b", k, bus.dp_issue, e_issue); end
      if (bus.read_address !== e_raddr) begin miscompares++; $display("FAIL five_read_address c%0d: got %0d, expected %0d", k, bus.read_address, e_raddr); end
      if (bus.write_enable !== e_we) begin miscompares++; $display("FAIL five_write_enable c%0d: got %b, expected %b", k, bus.write_enable, e_we); end
      if (bus.finish !== e_fin) begin miscompares++; $display("FAIL five_finish c%0d: got %b, expected %b", k, bus.finish, e_fin); end
      if (bus.busy !== e_busy) begin miscompares++; $display("FAIL five_busy c%0d: got %b, expected %b", k, bus.busy, e_busy); end
      if (e_we) begin
        vectors++;
        if (bus.write_address !== AW'(k - 6)) begin miscompares++; $display("FAIL five_write_address c%0d: got %0d, expected %0d", k, bus.write_address, k - 6); end
      end
    end
    vectors += 3;
    if (wr_count !== 5)  begin miscompares++; $display("FAIL five_writes: got %0d, expected 5", wr_count); end
    if (fin_count !== 1) begin miscompares++; $display("FAIL five_finishes: got %0d, expected 1", fin_count); end
    if (sb.size() !== 0) begin miscompares++; $display("FAIL five_sb_empty: got %0d pending, expected 0", sb.size()); end
    $display("five-row pass checked");
  endtask

  task automatic test_zero_rows;
    wr_count = 0; fin_count = 0;
    launch(0);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      vectors += 4;
      if (bus.dp_issue !== 1'b0) begin miscompares++; $display("FAIL zero_dp_issue c%0d: got %b, expected 0", k, bus.dp_issue); end
      if (bus.write_enable !== 1'b0) begin miscompares++; $display("FAIL zero_write_enable c%0d: got %b, expected 0", k, bus.write_enable); end
      if (bus.finish !== (k == 1)) begin miscompares++; $display("FAIL zero_finish c%0d: got %b, expected %b", k, bus.finish, (k == 1)); end
      if (bus.busy !== (k == 1)) begin miscompares++; $display("FAIL zero_busy c%0d: got %b, expected %b", k, bus.busy, (k == 1)); end
    end
    vectors++;
    if (fin_count !== 1) begin miscompares++; $display("FAIL zero_finishes: got %0d, expected 1", fin_count); end
    $display("zero-row pass checked");
  endtask

  task automatic test_clamp;
    bit ok;
    wr_count = 0; fin_count = 0; last_wr_addr = -1;
    launch(2000);
    wait_finish(1200, ok);
    @(negedge clk);
    vectors += 5;
    if (!ok) begin miscompares++; $display("FAIL clamp_timeout: got no finish, expected finish within 1200 cycles"); end
    if (wr_count !== 1001) begin miscompares++; $display("FAIL clamp_writes: got %0d, expected 1001", wr_count); end
    if (last_wr_addr !== 1000) begin miscompares++; $display("FAIL clamp_last_addr: got %0d, expected 1000", last_wr_addr); end
    if (fin_count !== 1) begin miscompares++; $display("FAIL clamp_finishes: got %0d, expected 1", fin_count); end
    if (sb.size() !== 0) begin miscompares++; $display("FAIL clamp_sb_empty: got %0d pending, expected 0", sb.size()); end
    $display("clamp pass checked");
  endtask

  task automatic test_start_ignored;
    bit ok;
    wr_count = 0; fin_count = 0;
    launch(5);
    @(negedge clk);
    bus.start = 1'b1; bus.row_count = AW'(7);
    @(negedge clk);
    bus.start = 1'b0;
    wait_finish(40, ok);
    repeat (4) @(negedge clk);
    vectors += 4;
    if (!ok) begin miscompares++; $display("FAIL ignore_timeout: got no finish, expected finish"); end
    if (wr_count !== 5) begin miscompares++; $display("FAIL ignore_writes: got %0d, expected 5", wr_count); end
    if (fin_count !== 1) begin miscompares++; $display("FAIL ignore_finishes: got %0d, expected 1", fin_count); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL ignore_idle: got busy %b, expected 0", bus.busy); end
    $display("second start ignored checked");
  endtask

  task automatic test_mid_reset;
    bit ok;
    launch(5);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors += 6;
    if (bus.read_address !== '0) begin miscompares++; $display("FAIL mrst_read_address: got %0d, expected 0", bus.read_address); end
    if (bus.dp_issue !== 1'b0)   begin miscompares++; $display("FAIL mrst_dp_issue: got %b, expected 0", bus.dp_issue); end
    if (bus.busy !== 1'b0)       begin miscompares++; $display("FAIL mrst_busy: got %b, expected 0", bus.busy); end
    if (bus.write_enable !== 1'b0) begin miscompares++; $display("FAIL mrst_write_enable: got %b, expected 0", bus.write_enable); end
    if (bus.write_address !== '0) begin miscompares++; $display("FAIL mrst_write_address: got %0d, expected 0", bus.write_address); end
    if (bus.finish !== 1'b0)     begin miscompares++; $display("FAIL mrst_finish: got %b, expected 0", bus.finish); end
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_count = 0; fin_count = 0;
    repeat (12) @(negedge clk);
    vectors += 2;
    if (wr_count !== 0)  begin miscompares++; $display("FAIL mrst_no_writes: got %0d, expected 0", wr_count); end
    if (fin_count !== 0) begin miscompares++; $display("FAIL mrst_no_finish: got %0d, expected 0", fin_count); end
    launch(5);
    wait_finish(40, ok);
    @(negedge clk);
    vectors += 3;
    if (!ok) begin miscompares++; $display("FAIL mrst_restart_timeout: got no finish, expected finish"); end
    if (wr_count !== 5)  begin miscompares++; $display("FAIL mrst_restart_writes: got %0d, expected 5", wr_count); end
    if (fin_count !== 1) begin miscompares++; $display("FAIL mrst_restart_finish: got %0d, expected 1", fin_count); end
    $display("mid-pass reset checked");
  endtask

  // Passes started on the first idle cycle after each finish.
  task automatic test_back_to_back;
    bit ok;
    int rows;
    int total;
    wr_count = 0; fin_count = 0; total = 0;
    for (int p = 0; p < 5; p++) begin
      rows = (p == 0) ? 1 : int'($urandom_range(1, 20));
      total += rows;
      bus.start = 1'b1; bus.row_count = AW'(rows);
      @(negedge clk);
      bus.start = 1'b0;
      wait_finish(60, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL b2b_timeout pass %0d: got no finish, expected finish", p); end
      @(negedge clk);
      $display("pass %0d rows=%0d done", p, rows);
    end
    vectors += 3;
    if (wr_count !== total) begin miscompares++; $display("FAIL b2b_writes: got %0d, expected %0d", wr_count, total); end
    if (fin_count !== 5) begin miscompares++; $display("FAIL b2b_finishes: got %0d, expected 5", fin_count); end
    if (sb.size() !== 0) begin miscompares++; $display("FAIL b2b_sb_empty: got %0d pending, expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_five_rows();
    test_zero_rows();
    test_clamp();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
